// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the dmem port between CPU and DMA, with fixed CPU priority and starvation-forced DMA grants
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_wen,
  input  logic                  cpu_byt,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [15:0]           cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [15:0]           cpu_rdata,
  input  logic                  dma_req,
  input  logic                  dma_wen,
  input  logic                  dma_byt,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [15:0]           dma_wdata,
  output logic                  dma_gnt,
  output logic                  dma_rvalid,
  output logic [15:0]           dma_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wen,
  output logic                  mem_byt,
  output logic [15:0]           mem_wdata,
  input  logic [15:0]           mem_rdata
);
  localparam int CW = MAX_WAIT > 0 ? $clog2(MAX_WAIT + 1) : 1;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          rd_cpu_q, rd_dma_q;
  logic          force_dma;
  always_comb begin
    force_dma  = dma_req && (wait_cnt_q == CW'(MAX_WAIT));
    dma_gnt    = !rst && dma_req && (force_dma || !cpu_req);
    cpu_gnt    = !rst && cpu_req && !dma_gnt;
    wait_cnt_d = (dma_req && !dma_gnt) ?
                 ((wait_cnt_q == CW'(MAX_WAIT)) ? wait_cnt_q : wait_cnt_q + 1'b1) : '0;
    mem_addr   = dma_gnt ? dma_addr  : cpu_gnt ? cpu_addr  : '0;
    mem_wen    = dma_gnt ? dma_wen   : cpu_gnt ? cpu_wen   : 1'b0;
    mem_byt    = dma_gnt ? dma_byt   : cpu_gnt ? cpu_byt   : 1'b0;
    mem_wdata  = dma_gnt ? dma_wdata : cpu_gnt ? cpu_wdata : '0;
    // a read whose return cycle coincides with reset is dropped, not delivered
    cpu_rvalid = rd_cpu_q && !rst;
    dma_rvalid = rd_dma_q && !rst;
    cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    dma_rdata  = dma_rvalid ? mem_rdata : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
      rd_cpu_q   <= 1'b0;
      rd_dma_q   <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      rd_cpu_q   <= cpu_gnt && !cpu_wen;
      rd_dma_q   <= dma_gnt && !dma_wen;
    end
  end
endmodule
